// File: rtl/mld_7_4_frame_sequencer.sv
// Frame sequencer for the serial (7,4) majority logic decoder: loads a codeword bit-serially, runs the decode cycles, holds the result.
// Optional saturating corrected-frame counter enabled by defining MLD_SEQ_ERR_COUNT_EN.
module mld_7_4_frame_sequencer #(
  parameter int N             = 7,
  parameter int DECODE_CYCLES = 7,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_codeword,
  output logic             dec_load,
  output logic             dec_bit,
  input  logic [N-1:0]     dec_vector,
  input  logic             dec_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_vector,
  output logic             out_corrected,
  output logic [CNT_W-1:0] frame_count
`ifdef MLD_SEQ_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  localparam int BW = $clog2(N + 1);
  localparam int CW = (DECODE_CYCLES > 1) ? $clog2(DECODE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DECODE, HOLD} state_t;

  state_t          state;
  logic [N-1:0]    shift_reg;
  logic [BW-1:0]   bit_cnt;
  logic [CW-1:0]   cyc_cnt;
  logic            corr_flag;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  // bit 0 goes out on the accept edge itself, so the shift register keeps only the remaining bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      cyc_cnt       <= '0;
      corr_flag     <= 1'b0;
      dec_load      <= 1'b0;
      dec_bit       <= 1'b0;
      out_vector    <= '0;
      out_corrected <= 1'b0;
      frame_count   <= '0;
`ifdef MLD_SEQ_ERR_COUNT_EN
      err_count     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= in_codeword >> 1;
            dec_bit   <= in_codeword[0];
            dec_load  <= 1'b1;
            bit_cnt   <= BW'(1);
            corr_flag <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (bit_cnt == BW'(N)) begin
            dec_load <= 1'b0;
            dec_bit  <= 1'b0;
            cyc_cnt  <= '0;
            state    <= DECODE;
          end else begin
            dec_bit   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        DECODE: begin
          // the last decode cycle's error still counts toward this frame
          if (cyc_cnt == CW'(DECODE_CYCLES - 1)) begin
            out_vector    <= dec_vector;
            out_corrected <= corr_flag | dec_error;
            state         <= HOLD;
          end else begin
            corr_flag <= corr_flag | dec_error;
            cyc_cnt   <= cyc_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            frame_count <= frame_count + 1'b1;
`ifdef MLD_SEQ_ERR_COUNT_EN
            if (out_corrected && (err_count != '1))
              err_count <= err_count + 1'b1;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
